search_datapath: RTL and testbench

- Datapath responder for the sequential table-search controller. It holds a small writable table, an address counter, a data register and a key comparator.
- It executes the controller's `datapath_load` and `datapath_mv_addr` strobes and returns `datapath_found`.
- `datapath_found` stops the controller on either a key match or table exhaustion. `hit` tells the two cases apart.

---
 rtl/search_datapath.sv | 88 ++++++++
 tb/tb_search_datapath.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/search_datapath.sv
// search_datapath: table, address counter, data register and key comparator
// serving a sequential table-search controller. Reports a stop condition
// (key match or end of table) on datapath_found, with hit telling them apart.
module search_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] key,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              datapath_load,
  input  logic              datapath_mv_addr,
  output logic              datapath_found,
  output logic              hit,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_q
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_d;
  logic              hit_q, hit_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] rd_data;
  logic              wr_ok;

  assign rd_data = mem_q[addr_q];
  assign wr_ok   = wr_en && ({1'b0, wr_addr} < DEPTH_EXT);

  // Table storage: never reset, so contents survive reset and clear
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Next-state: clear wins; otherwise load samples the pre-move address and
  // the move is gated by the hit value held before this edge
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    hit_d  = hit_q;
    last_d = last_q;
    if (clear) begin
      addr_d = '0;
      data_d = '0;
      hit_d  = 1'b0;
      last_d = 1'b0;
    end else begin
      if (datapath_load) begin
        data_d = rd_data;
        hit_d  = (rd_data == key);
        last_d = (addr_q == LAST_ADDR);
      end
      if (datapath_mv_addr && !hit_q) begin
        addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
      end
    end
  end

  // Search state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      data_q <= '0;
      hit_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      hit_q  <= hit_d;
      last_q <= last_d;
    end
  end

  assign addr           = addr_q;
  assign hit            = hit_q;
  assign datapath_found = hit_q | last_q;

endmodule

// File: tb/tb_search_datapath.sv
// Bench for search_datapath: directed search scenarios followed by random
// traffic, all checked against a behavioural model of the table search.
module tb_search_datapath;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              reset;
  logic              clear;
  logic [DATA_W-1:0] key;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              datapath_load;
  logic              datapath_mv_addr;
  logic              datapath_found;
  logic              hit;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_q;

  int total;
  int bad;

  // behavioural model state
  int  m_mem [DEPTH];
  int  m_addr;
  int  m_data;
  bit  m_hit;
  bit  m_last;

  search_datapath #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .key(key),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .datapath_load(datapath_load),
    .datapath_mv_addr(datapath_mv_addr),
    .datapath_found(datapath_found),
    .hit(hit),
    .addr(addr),
    .data_q(data_q)
  );

  // free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic compareModel();
    checkOutput("addr", int'(addr), m_addr);
    checkOutput("data_q", int'(data_q), m_data);
    checkOutput("hit", int'(hit), int'(m_hit));
    checkOutput("found", int'(datapath_found), int'(m_hit | m_last));
  endtask

  // drive one clock cycle of controls, advance the model, then compare
  task automatic applyStimulus(input bit clr, input bit ld, input bit mv,
                               input bit we, input int wa, input int wd);
    int  rd;
    bit  old_hit;
    clear            = clr;
    datapath_load    = ld;
    datapath_mv_addr = mv;
    wr_en            = we;
    wr_addr          = ADDR_W'(wa);
    wr_data          = DATA_W'(wd);
    @(posedge clk);
    rd      = m_mem[m_addr];
    old_hit = m_hit;
    if (clr) begin
      m_addr = 0; m_data = 0; m_hit = 0; m_last = 0;
    end else begin
      if (ld) begin
        m_data = rd;
        m_hit  = (rd == int'(key));
        m_last = (m_addr == DEPTH - 1);
      end
      if (mv && !old_hit) m_addr = (m_addr + 1) % DEPTH;
    end
    if (we && wa < DEPTH) m_mem[wa] = wd;
    #1;
    compareModel();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  // one controller round: load, idle, move, idle
  task automatic searchStep();
    applyStimulus(0, 1, 0, 0, 0, 0);
    idle();
    applyStimulus(0, 0, 1, 0, 0, 0);
    idle();
  endtask

  task automatic moveTo(input int target);
    for (int n = 0; n < target; n++) applyStimulus(0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    m_addr = 0; m_data = 0; m_hit = 0; m_last = 0;
    reset = 1'b0; clear = 1'b0; key = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; datapath_load = 1'b0; datapath_mv_addr = 1'b0;

    // reset state
    #12;
    compareModel();
    checkOutput("reset_found", int'(datapath_found), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // table fill: mem[i] = i*3
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 1, i, i * 3);

    // key 12 hits at address 4, and the move after the hit holds addr
    $display("[TB] search key=12");
    key = 8'd12;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("miss_found", int'(datapath_found), 0);
      idle();
      applyStimulus(0, 0, 1, 0, 0, 0);
      idle();
    end
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("hit4_hit", int'(hit), 1);
    checkOutput("hit4_data", int'(data_q), 12);
    idle();
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("hit4_hold", int'(addr), 4);

    // clear after hit, then key 0 hits at address 0
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("clr_addr", int'(addr), 0);
    checkOutput("clr_found", int'(datapath_found), 0);
    key = 8'd0;
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("key0_hit", int'(hit), 1);

    // exhaustion with key 200
    $display("[TB] search key=200");
    applyStimulus(1, 0, 0, 0, 0, 0);
    key = 8'd200;
    for (int i = 0; i < DEPTH - 1; i++) searchStep();
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("exh_found", int'(datapath_found), 1);
    checkOutput("exh_hit", int'(hit), 0);
    checkOutput("exh_data", int'(data_q), 45);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("exh_wrap", int'(addr), 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("exh_relast", int'(datapath_found), 0);

    // load and move together at address 2
    applyStimulus(1, 0, 0, 0, 0, 0);
    key = 8'd6;
    moveTo(2);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("lm_data", int'(data_q), 6);
    checkOutput("lm_hit", int'(hit), 1);
    checkOutput("lm_addr", int'(addr), 3);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("lm_hold", int'(addr), 3);

    // load with a same-cycle write to the current address
    applyStimulus(1, 0, 0, 0, 0, 0);
    key = 8'd250;
    moveTo(1);
    applyStimulus(0, 1, 0, 1, 1, 99);
    checkOutput("lw_old", int'(data_q), 3);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("lw_new", int'(data_q), 99);

    // asynchronous reset in the middle of a search
    applyStimulus(1, 0, 0, 0, 0, 0);
    key = 8'd21;
    moveTo(7);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("pre_rst_hit", int'(hit), 1);
    #2;
    reset = 1'b0;
    #1;
    m_addr = 0; m_data = 0; m_hit = 0; m_last = 0;
    checkOutput("arst_addr", int'(addr), 0);
    checkOutput("arst_data", int'(data_q), 0);
    checkOutput("arst_hit", int'(hit), 0);
    checkOutput("arst_found", int'(datapath_found), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    moveTo(7);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("mem7_kept", int'(data_q), 21);

    // random traffic
    $display("[TB] random phase");
    for (int n = 0; n < 600; n++) begin
      bit clr_r, ld_r, mv_r, we_r;
      int wa_r, wd_r;
      if ($urandom_range(0, 19) == 0) begin
        key = DATA_W'(m_mem[$urandom_range(0, DEPTH - 1)]);
      end
      clr_r = ($urandom_range(0, 24) == 0);
      ld_r  = ($urandom_range(0, 2) == 0);
      mv_r  = ($urandom_range(0, 1) == 0);
      we_r  = ($urandom_range(0, 4) == 0);
      wa_r  = int'($urandom_range(0, DEPTH - 1));
      wd_r  = int'($urandom_range(0, 63));
      applyStimulus(clr_r, ld_r, mv_r, we_r, wa_r, wd_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
